// File: rtl/lfsr_pkg.sv
// Shared LFSR helpers: the single-step Fibonacci update and a W-step
// unrolled word generator. Functions work on fixed maximum widths, so any
// module with N <= LFSR_MAX_N and W <= LFSR_MAX_W can call them after
// zero-extending its operands.
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_N = 64;
  localparam int unsigned LFSR_MAX_W = 64;

  typedef logic [LFSR_MAX_N-1:0] lfsr_state_t;
  typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

  // Result of generating one word: the emitted bits (bit 0 oldest) and the
  // state after all W steps.
  typedef struct packed {
    lfsr_word_t  word;
    lfsr_state_t next_state;
  } lfsr_word_res_t;

  // Control states of the stream front end.
  typedef enum logic [1:0] {
    ST_START    = 2'd0,
    ST_WAIT_CFG = 2'd1,
    ST_RUN      = 2'd2
  } lfsr_fsm_e;

  // One Fibonacci step: feedback is the XOR of the tapped bits, shifted in
  // at the top of an n-bit register. Bits at or above n stay zero as long as
  // state and taps are zero there.
  function automatic lfsr_state_t lfsr_step(lfsr_state_t state,
                                            lfsr_state_t taps,
                                            int unsigned n);
    logic fb;
    fb = ^(state & taps);
    return (state >> 1) | (lfsr_state_t'(fb) << (n - 1));
  endfunction

  // W steps unrolled: word[j] is state bit 0 after j steps.
  function automatic lfsr_word_res_t lfsr_word(lfsr_state_t state,
                                               lfsr_state_t taps,
                                               int unsigned n,
                                               int unsigned w);
    lfsr_word_res_t res;
    lfsr_state_t    s;
    res = '0;
    s   = state;
    for (int j = 0; j < int'(LFSR_MAX_W); j++) begin
      if (j < int'(w)) begin
        res.word[j] = s[0];
        s           = lfsr_step(s, taps, n);
      end
    end
    res.next_state = s;
    return res;
  endfunction

endpackage

// File: rtl/lfsr_stream_if.sv
// Stream and configuration bundle of lfsr_stream. The slave side is the
// generator; the master side is the consumer that also supplies config.
interface lfsr_stream_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 1,
  parameter int unsigned CNT_W = 32
);

  logic             load_config_i;
  logic [N-1:0]     taps_i;
  logic [N-1:0]     start_value_i;
  logic             ready_i;
  logic [W-1:0]     data_o;
  logic             valid_o;
  logic             lockup_o;
  logic [CNT_W-1:0] word_cnt_o;

  modport slave (
    input  load_config_i,
    input  taps_i,
    input  start_value_i,
    input  ready_i,
    output data_o,
    output valid_o,
    output lockup_o,
    output word_cnt_o
  );

  modport master (
    output load_config_i,
    output taps_i,
    output start_value_i,
    output ready_i,
    input  data_o,
    input  valid_o,
    input  lockup_o,
    input  word_cnt_o
  );

endinterface

// File: rtl/lfsr_core.sv
// LFSR state and tap registers plus the combinational W-step word
// generator. The core only moves when told to: load_i replaces taps and
// state, advance_i steps the state by one whole word.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned N               = 8,
  parameter int unsigned W               = 1,
  parameter logic [N-1:0] START_VALUE    = N'(8'h01),
  parameter logic [N-1:0] TAPS           = N'(8'h03),
  parameter bit           VARIABLE_CONFIG = 1'b0
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         load_i,
  input  logic [N-1:0] taps_i,
  input  logic [N-1:0] seed_i,
  input  logic         advance_i,
  output logic [W-1:0] word_o,
  output logic [N-1:0] state_next_o
);

  logic [N-1:0]   state_q, state_d;
  logic [N-1:0]   taps_q, taps_d;
  logic [N-1:0]   word_next_state;
  lfsr_word_res_t word_res;
  logic           word_res_unused;

  // Word and post-word state generated from the current register contents.
  always_comb begin
    word_res = lfsr_word(lfsr_state_t'(state_q), lfsr_state_t'(taps_q), N, W);
  end

  assign word_o          = word_res.word[W-1:0];
  assign word_next_state = word_res.next_state[N-1:0];
  // Upper bits of the max-width result are always zero here.
  assign word_res_unused = ^word_res;

  // Next-state selection: a config load wins over a word advance.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    taps_d  = taps_q;
    if (load_i) begin
      state_d = seed_i;
      taps_d  = taps_i;
    end else if (advance_i) begin
      state_d = word_next_state;
    end
  end

  // State and taps registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so all flops update from pre-edge values.
    if (!reset_ni) begin
      state_q <= VARIABLE_CONFIG ? N'(0) : START_VALUE;
      taps_q  <= TAPS;
    end else begin
      state_q <= state_d;
      taps_q  <= taps_d;
    end
  end

  assign state_next_o = state_d;

endmodule

// File: rtl/lfsr_stream.sv
// Multi-bit LFSR stream source: W sequence bits per word behind a
// valid/ready port with backpressure, optional run-time taps/seed, a
// transfer counter and an all-zero lock-up flag.
module lfsr_stream
  import lfsr_pkg::*;
#(
  parameter int unsigned N                = 8,
  parameter int unsigned W                = 1,
  parameter logic [N-1:0] START_VALUE     = N'(8'h01),
  parameter logic [N-1:0] TAPS            = N'(8'h03),
  parameter bit           VARIABLE_CONFIG = 1'b0,
  parameter int unsigned CNT_W            = 32
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  lfsr_stream_if.slave  bus
);

  lfsr_fsm_e        fsm_q, fsm_d;
  logic [W-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic             lockup_q, lockup_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cfg_load;
  logic             advance;
  logic             xfer;
  logic [W-1:0]     core_word;
  logic [N-1:0]     core_state_next;

  // Config loads only exist in the run-time configurable build.
  assign cfg_load = VARIABLE_CONFIG && bus.load_config_i;
  assign xfer     = valid_q && bus.ready_i;

  lfsr_core #(
    .N               (N),
    .W               (W),
    .START_VALUE     (START_VALUE),
    .TAPS            (TAPS),
    .VARIABLE_CONFIG (VARIABLE_CONFIG)
  ) u_core (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .load_i       (cfg_load),
    .taps_i       (bus.taps_i),
    .seed_i       (bus.start_value_i),
    .advance_i    (advance),
    .word_o       (core_word),
    .state_next_o (core_state_next)
  );

  // FSM, output register, counter and lock-up flag next values. A load
  // discards any pending word, so the transfer in that cycle is not counted.
  always_comb begin
    fsm_d    = fsm_q;
    data_d   = data_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    advance  = 1'b0;
    if (cfg_load) begin
      fsm_d   = ST_RUN;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (fsm_q)
        ST_START:    fsm_d = VARIABLE_CONFIG ? ST_WAIT_CFG : ST_RUN;
        ST_WAIT_CFG: fsm_d = ST_WAIT_CFG;
        ST_RUN: begin
          if (xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (!valid_q || bus.ready_i) begin
            data_d  = core_word;
            valid_d = 1'b1;
            advance = 1'b1;
          end
        end
        default:     fsm_d = ST_START;
      endcase
    end
    // Lock-up tracks the state being written, and is never raised while
    // waiting for a configuration.
    lockup_d = (fsm_d == ST_RUN) ? (core_state_next == '0) : 1'b0;
  end

  // Registered FSM and outputs with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      fsm_q    <= VARIABLE_CONFIG ? ST_WAIT_CFG : ST_START;
      data_q   <= '0;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      fsm_q    <= fsm_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.data_o     = data_q;
  assign bus.valid_o    = valid_q;
  assign bus.lockup_o   = lockup_q;
  assign bus.word_cnt_o = cnt_q;

endmodule

// File: doc/lfsr_stream.md
# lfsr_stream

Parametrised successor to the single-bit Fibonacci LFSR. Emits `W` sequence bits per accepted word through a valid/ready stream port, with backpressure, optional run-time taps/seed loading, a word counter and an all-zero lock-up flag. Sits in the scrambler/PRBS path; feeds scramblers, BIST pattern sources and test-data generators that consume multi-bit words and may stall.

## Interface
- `N`, 8: LFSR state width, ≥2.
- `W`, 1: bits per output word, 1..64.
- `START_VALUE`, 8'b00000001: seed when `VARIABLE_CONFIG`=0 (N bits).
- `TAPS`, 8'b00000011: feedback tap mask, bit i set ⇒ state bit i in XOR (N bits).
- `VARIABLE_CONFIG`, 0: 1 ⇒ taps/seed come from ports via `load_config_i`.
- `CNT_W`, 32: word counter width.

- `clk_i` in 1: single clock.
- `reset_ni` in 1: synchronous, active-low reset.
- `load_config_i` in 1: load `taps_i`/`start_value_i` (used only if `VARIABLE_CONFIG`=1).
- `taps_i` in N: run-time tap mask.
- `start_value_i` in N: run-time seed.
- `ready_i` in 1: consumer accepts `data_o` this cycle.
- `data_o` out W: output word; `data_o[0]` is the oldest bit.
- `valid_o` out 1: `data_o` holds a word.
- `lockup_o` out 1: internal state is all-zero.
- `word_cnt_o` out CNT_W: number of words accepted since reset/load.

## Operation
- Step function, identical to the single-bit block: `nb` = XOR over i of `s[i] & taps[i]`; `s ← {nb, s[N-1:1]}`; emitted bit = `s[0]` before the step.
- Word generation: W steps unrolled combinationally from current state; `data_o[j]` = `s[0]` after j steps; state advances by W steps per generated word.
- States:
  - WAIT_CFG: only when `VARIABLE_CONFIG`=1 after reset; `valid_o`=0; leaves on `load_config_i`.
  - RUN: generates words.
- Output register: loads the next word when `!valid_o || ready_i`. Transfer occurs when `valid_o && ready_i`.
- `word_cnt_o` increments on every transfer; wraps modulo 2^CNT_W.
- `load_config_i` (VARIABLE_CONFIG=1, any state):
  - Captures taps and seed.
  - Drops any pending word: `valid_o`=0 next cycle, no transfer counted even if `ready_i`=1 that cycle.
  - Clears `word_cnt_o`.
  - Enters RUN.
- `load_config_i` is ignored when `VARIABLE_CONFIG`=0.
- Lock-up: `lockup_o` = (state == 0), registered alongside state. Generation continues and emits zero words; there is no auto-reseed.

## Timing
- Reset values: `data_o`=0, `valid_o`=0, `lockup_o`=0, `word_cnt_o`=0.
  - Internal state = `START_VALUE` (VARIABLE_CONFIG=0) or 0 with state WAIT_CFG (VARIABLE_CONFIG=1).
  - `lockup_o` stays 0 in WAIT_CFG.
- Latency:
  - First word: `valid_o`=1 on the second rising edge after `reset_ni` goes high, i.e. one cycle in RUN.
  - After a load: `valid_o`=1 on the edge after the edge that sampled `load_config_i`.
- Backpressure: while `valid_o && !ready_i`, `data_o`, state and counter are held; no bits are lost or skipped.
- Full throughput: one word per cycle while `ready_i`=1.
- Reset mid-stream: a pending word is discarded; the sequence restarts from the seed.

## Structure
- Package `lfsr_pkg`: `lfsr_step(state, taps)` function and `lfsr_word` unrolled-W function (returns word and next state). Shared with the existing LFSR and future scramblers.
- Sub-module `lfsr_core`: state and taps registers plus W-step next-state/word logic. The top level adds the FSM, output register, counter and lock-up flag.

## Test plan
- N=8, TAPS=8'h03, START=8'h01, W=8, `ready_i`=1 → words 8'h01, then 8'h81; `word_cnt_o` 1, 2; `valid_o` first high on the second edge after reset release.
- Same config with W=1 → bit stream 1,0,0,0,0,0,0,0,1,0; matches the single-bit LFSR bit-for-bit.
- W=8, `ready_i` held low for 5 cycles after the first valid → `data_o` stays 8'h01, `word_cnt_o` 0; on release, 8'h01 then 8'h81 with no gap.
- VARIABLE_CONFIG=1: no load → `valid_o` stays 0 for 20 cycles. Load taps 8'h03, seed 8'h01 while `valid_o`=1 and `ready_i`=1 → pending word dropped, counter 0, next word 8'h01.
- VARIABLE_CONFIG=1, seed 8'h00 → `lockup_o`=1, `data_o`=0 words continuously, counter still increments.
- Assert reset for 1 cycle after 3 transfers → all outputs 0; restart yields 8'h01 again.
